// File: rtl/compuertas_pkg.sv
// compuertas_bist shared types: gate op codes, sweep length and FSM states.
// Imported by the BIST controller, its reference model and the bus interface.
package compuertas_pkg;

  localparam logic [2:0] SEL_OFF  = 3'b000;
  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;
  localparam logic [2:0] SEL_NOR  = 3'b101;
  localparam logic [2:0] SEL_XNOR = 3'b110;

  localparam logic [2:0] ENT_LAST = 3'b111;

  // OFF check plus six ops times eight operand patterns
  localparam int NUM_VECTORS = 49;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OFFCHK,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/compuertas_if.sv
// Bus between the BIST controller (master) and the 3-input gate unit (slave).
// The master drives enable, op select and operands; the slave returns sal.
interface compuertas_if;
  import compuertas_pkg::*;

  logic       act;
  logic [2:0] sel;
  logic [2:0] ent;
  logic       sal;

  modport master (
    output act,
    output sel,
    output ent,
    input  sal
  );

  modport slave (
    input  act,
    input  sel,
    input  ent,
    output sal
  );

endinterface

// File: rtl/compuertas_ref_model.sv
// Combinational golden model of the 3-input gate unit.
// Disabled unit or unused select codes always produce 0.
module compuertas_ref_model
  import compuertas_pkg::*;
(
  input  logic       act_i,
  input  logic [2:0] sel_i,
  input  logic [2:0] ent_i,
  output logic       sal_o
);

  logic and3;
  logic or3;
  logic xor3;

  assign and3 = &ent_i;
  assign or3  = |ent_i;
  assign xor3 = ^ent_i;

  always_comb begin
    sal_o = 1'b0;
    if (act_i) begin
      unique case (sel_i)
        SEL_AND:  sal_o = and3;
        SEL_OR:   sal_o = or3;
        SEL_XOR:  sal_o = xor3;
        SEL_NAND: sal_o = ~and3;
        SEL_NOR:  sal_o = ~or3;
        SEL_XNOR: sal_o = ~xor3;
        default:  sal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/compuertas_bist.sv
// Power-on self-test for the gate unit: sweeps the OFF check and all ops,
// compares sal to the reference model and records the first failing vector.
module compuertas_bist
  import compuertas_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  compuertas_if.master     gate,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic             fail_valid_o,
  output logic [2:0]       fail_sel_o,
  output logic [2:0]       fail_ent_o
);

  localparam int CNT_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // OFFCHK already spends one settle cycle, so it waits one less
  localparam logic [CNT_W-1:0] WAIT_OP  =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_OFF =
    CNT_W'(SETTLE_CYCLES - 2);

  localparam logic [5:0] VEC_LAST = 6'(NUM_VECTORS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       vec_q;
  logic             act_q;
  logic [2:0]       sel_q;
  logic [2:0]       ent_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic             fvalid_q;
  logic [2:0]       fsel_q;
  logic [2:0]       fent_q;

  logic             exp_sal;
  logic             mismatch;
  logic             last_vec;
  logic [ERR_W-1:0] err_d;
  logic [2:0]       sel_d;
  logic [2:0]       ent_d;

  compuertas_ref_model u_ref (
    .act_i (act_q),
    .sel_i (sel_q),
    .ent_i (ent_q),
    .sal_o (exp_sal)
  );

  assign mismatch = (gate.sal != exp_sal);
  assign last_vec = (vec_q == VEC_LAST);

  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  // ent runs fastest; the OFF check hands over to AND/000
  always_comb begin
    sel_d = sel_q;
    ent_d = ent_q + 3'd1;
    if (!act_q) begin
      sel_d = SEL_AND;
      ent_d = '0;
    end else if (ent_q == ENT_LAST) begin
      sel_d = sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      vec_q    <= '0;
      act_q    <= 1'b0;
      sel_q    <= SEL_OFF;
      ent_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fsel_q   <= '0;
      fent_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fsel_q   <= '0;
            fent_q   <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            act_q    <= 1'b0;
            sel_q    <= SEL_AND;
            ent_q    <= ENT_LAST;
            vec_q    <= '0;
            state_q  <= ST_OFFCHK;
          end
        end
        ST_OFFCHK: begin
          if (SETTLE_CYCLES == 1) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q   <= WAIT_OFF;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          if (mismatch && !fvalid_q) begin
            fvalid_q <= 1'b1;
            fsel_q   <= act_q ? sel_q : SEL_OFF;
            fent_q   <= ent_q;
          end
          if (last_vec) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == '0);
            act_q   <= 1'b0;
            sel_q   <= SEL_OFF;
            ent_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            act_q   <= 1'b1;
            sel_q   <= sel_d;
            ent_q   <= ent_d;
            vec_q   <= vec_q + 6'd1;
            cnt_q   <= WAIT_OP;
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gate.act     = act_q;
  assign gate.sel     = sel_q;
  assign gate.ent     = ent_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign fail_valid_o = fvalid_q;
  assign fail_sel_o   = fsel_q;
  assign fail_ent_o   = fent_q;

endmodule

// File: tb/tb_compuertas_bist.sv
// Directed bench for compuertas_bist: a behavioural gate unit with
// selectable faults, checked against hand-computed sweep results.
module tb_compuertas_bist;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  int   dones;

  logic       busy8, done8, pass8, fv8;
  logic [7:0] err8;
  logic [2:0] fsel8, fent8;
  logic       busy4, done4, pass4, fv4;
  logic [3:0] err4;
  logic [2:0] fsel4, fent4;

  always #5 clk = ~clk;

  compuertas_if bus8 ();
  compuertas_if bus4 ();

  // mode: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
  function automatic logic gate_model(
    input int m, input logic a,
    input logic [2:0] s, input logic [2:0] e);
    int   k;
    logic r;
    k = $countones(e);
    r = 1'b0;
    if (a) begin
      case (s)
        3'd1: r = (k == 3);
        3'd2: r = (k != 0);
        3'd3: r = (k % 2 == 1);
        3'd4: r = (k != 3);
        3'd5: r = (k == 0);
        3'd6: r = (k % 2 == 0);
        default: r = 1'b0;
      endcase
    end
    case (m)
      1: r = 1'b0;
      2: r = 1'b1;
      3: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  assign bus8.sal = gate_model(mode, bus8.act,
                               bus8.sel, bus8.ent);
  assign bus4.sal = gate_model(mode, bus4.act,
                               bus4.sel, bus4.ent);

  compuertas_bist #(.SETTLE_CYCLES(2), .ERR_W(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .gate         (bus8),
    .busy_o       (busy8),
    .done_o       (done8),
    .pass_o       (pass8),
    .err_count_o  (err8),
    .fail_valid_o (fv8),
    .fail_sel_o   (fsel8),
    .fail_ent_o   (fent8)
  );

  compuertas_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .gate         (bus4),
    .busy_o       (busy4),
    .done_o       (done4),
    .pass_o       (pass4),
    .err_count_o  (err4),
    .fail_valid_o (fv4),
    .fail_sel_o   (fsel4),
    .fail_ent_o   (fent4)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_act"},  int'(bus8.act), 0);
    chk({p, "_sel"},  int'(bus8.sel), 0);
    chk({p, "_ent"},  int'(bus8.ent), 0);
    chk({p, "_busy"}, int'(busy8), 0);
    chk({p, "_done"}, int'(done8), 0);
    chk({p, "_pass"}, int'(pass8), 0);
    chk({p, "_err"},  int'(err8), 0);
    chk({p, "_fv"},   int'(fv8), 0);
    chk({p, "_fsel"}, int'(fsel8), 0);
    chk({p, "_fent"}, int'(fent8), 0);
    chk({p, "_err4"}, int'(err4), 0);
  endtask

  // Start on the next edge; n = edges until done seen (148 expected)
  task automatic sweep(input string p, input int hold);
    start = 1'b1;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (n == 1) begin
        if (hold == 0) start = 1'b0;
        chk({p, "_busy1"}, int'(busy8), 1);
        chk({p, "_offvec"},
            int'({bus8.act, bus8.sel, bus8.ent}), 7'b0001111);
      end
      if (n == 4) begin
        chk({p, "_vec1"},
            int'({bus8.act, bus8.sel, bus8.ent}), 7'b1001000);
      end
      if (done8) break;
    end
    chk({p, "_latency"}, n, 148);
    chk({p, "_done4"}, int'(done4), 1);
    chk({p, "_busy_done"}, int'(busy8), 0);
    chk({p, "_idlevec"},
        int'({bus8.act, bus8.sel, bus8.ent}), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // good unit
    sweep("good", 0);
    chk("good_pass", int'(pass8), 1);
    chk("good_err", int'(err8), 0);
    chk("good_fv", int'(fv8), 0);
    chk("good_pass4", int'(pass4), 1);
    tick();
    chk("good_done_pulse", int'(done8), 0);
    chk("good_pass_hold", int'(pass8), 1);

    // stuck-at-0
    mode = 1;
    sweep("sa0", 0);
    chk("sa0_err", int'(err8), 24);
    chk("sa0_pass", int'(pass8), 0);
    chk("sa0_fv", int'(fv8), 1);
    chk("sa0_fsel", int'(fsel8), 1);
    chk("sa0_fent", int'(fent8), 7);
    tick();

    // stuck-at-1, also saturating the narrow counter
    mode = 2;
    sweep("sa1", 0);
    chk("sa1_err", int'(err8), 25);
    chk("sa1_pass", int'(pass8), 0);
    chk("sa1_fsel", int'(fsel8), 0);
    chk("sa1_fent", int'(fent8), 7);
    chk("sa1_err4", int'(err4), 15);
    chk("sa1_fsel4", int'(fsel4), 0);
    tick();

    // inverted output
    mode = 3;
    sweep("inv", 0);
    chk("inv_err", int'(err8), 49);
    chk("inv_pass", int'(pass8), 0);
    chk("inv_fsel", int'(fsel8), 0);
    chk("inv_fent", int'(fent8), 7);
    chk("inv_err4", int'(err4), 15);
    tick();

    // reset in the middle of a sweep
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (59) tick();
    chk("mid_busy", int'(busy8), 1);
    rst = 1'b1;
    tick();
    chk_reset("abort");
    rst = 1'b0;
    dones = 0;
    repeat (200) begin
      tick();
      if (done8) dones++;
    end
    chk("abort_no_done", dones, 0);
    sweep("after", 0);
    chk("after_pass", int'(pass8), 1);
    tick();

    // start held high for the whole sweep
    mode = 1;
    sweep("hold", 1);
    chk("hold_err", int'(err8), 24);
    tick();
    chk("hold_idle_busy", int'(busy8), 0);
    chk("hold_idle_done", int'(done8), 0);
    tick();
    chk("hold_restart", int'(busy8), 1);
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
